pad_io_ctrl: RTL and testbench
==============================

PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

Interface
REQ-001 SHALL have parameter TURN_CYC, default 2: guard cycles with the driver tri-stated on each direction change.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, minimum 2.
REQ-003 SHALL have parameter FILT_W, default 4: glitch-filter counter width.
REQ-004 SHALL have ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, synchronous, active-high.
- dir_req_i  in  1  requested direction (1 = drive pad, 0 = receive).
- out_data_i  in  1  value to drive when in output mode.
- filt_len_i  in  FILT_W  glitch-filter length in cycles, minus 1.
- pad_oen_o  out  1  to pad OEN (1 = tri-stated, 0 = driving).
- pad_i_o  out  1  to pad I.
- pad_o_i  in  1  from pad O; asynchronous.
- dir_o  out  1  effective direction (1 only in OUT state).
- busy_o  out  1  turnaround in progress.
- in_data_o  out  1  synchronized, filtered pad value.
- rise_o  out  1  one-cycle pulse on a 0->1 change of in_data_o.
- fall_o  out  1  one-cycle pulse on a 1->0 change of in_data_o.

Function
REQ-005 SHALL implement FSM states IN, TO_OUT, OUT, TO_IN; all outputs registered.
REQ-006 IN: pad_oen_o=1; dir_req_i=1 -> TO_OUT (or OUT directly if TURN_CYC=0).
REQ-007 TO_OUT: pad_oen_o=1, busy_o=1; after exactly TURN_CYC cycles -> OUT.
REQ-008 OUT: pad_oen_o=0, dir_o=1; dir_req_i=0 -> TO_IN (or IN directly if TURN_CYC=0).
REQ-009 TO_IN: pad_oen_o=1 from its first cycle, busy_o=1; after exactly TURN_CYC cycles -> IN.
REQ-010 Changes to dir_req_i during TO_OUT/TO_IN SHALL be ignored until the turnaround completes; the request is then re-evaluated from the arrived state.
REQ-011 pad_i_o SHALL follow out_data_i with one-cycle latency in TO_OUT and OUT; it SHALL hold its last value in IN and TO_IN.
REQ-012 pad_o_i SHALL pass through a SYNC_STAGES flop chain in every state.
REQ-013 Filter counter SHALL increment while the synced value differs from in_data_o and clear when they are equal.
REQ-014 When the count equals filt_len_i and the values still differ, in_data_o SHALL toggle on the next edge and the counter SHALL clear.
REQ-015 Latency from a stable pad change to in_data_o is SYNC_STAGES+filt_len_i+1 cycles.
REQ-016 Pulses shorter than filt_len_i+1 synced cycles SHALL be rejected.
REQ-017 Outside state IN, the filter counter SHALL be held at 0 and in_data_o SHALL hold.
REQ-018 rise_o/fall_o SHALL pulse in the same cycle in_data_o changes; they are never both 1.
REQ-019 The turnaround counter SHALL saturate-free count 0..TURN_CYC-1 and SHALL never wrap.

Reset
REQ-020 On rst_i=1 at a clock edge: state IN, pad_oen_o=1, pad_i_o=0, dir_o=0, busy_o=0, in_data_o=0, rise_o=0, fall_o=0, sync flops 0, counters 0.
REQ-021 Reset mid-turnaround or in OUT SHALL tri-state the pad on the very next edge.
REQ-022 No edge pulse SHALL be generated by reset itself.

Configuration
REQ-023 Macro PAD_IO_CTRL_EDGE_EN defined: rise_o/fall_o are generated as specified.
REQ-024 Macro PAD_IO_CTRL_EDGE_EN undefined: rise_o/fall_o are tied to 0, edge logic is absent, and ports are unchanged.

Structure
REQ-025 Package pad_io_ctrl_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-026 Synchronizer plus glitch filter SHALL be the sub-module pad_in_filter, instantiated once.

Verification
REQ-027 Reset, then dir_req_i=1 with TURN_CYC=2 -> busy_o=1 for 2 cycles, then pad_oen_o=0 and dir_o=1.
REQ-028 In OUT, drop dir_req_i -> pad_oen_o=1 on the next edge, busy_o=1 for 2 cycles, then IN.
REQ-029 IN state, filt_len_i=3, pad_o_i 0->1 held -> in_data_o=1 and rise_o=1 exactly 6 cycles later.
REQ-030 filt_len_i=3, pad_o_i 3-cycle high glitch -> in_data_o stays 0 and no pulse.
REQ-031 Toggle dir_req_i 1->0 during TO_OUT -> OUT is reached after 2 cycles, then TO_IN follows.
REQ-032 rst_i asserted in OUT with pad driving -> next edge pad_oen_o=1 and all outputs at reset values.

Source files
------------

// File: rtl/pad_io_ctrl_pkg.sv
// rtl/pad_io_ctrl_pkg.sv - shared FSM state type and default parameters for pad_io_ctrl
package pad_io_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IN     = 2'd0,
    ST_TO_OUT = 2'd1,
    ST_OUT    = 2'd2,
    ST_TO_IN  = 2'd3
  } pad_state_e;

  localparam int TURN_CYC_DEF    = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_W_DEF      = 4;

endpackage

// File: rtl/pad_in_filter.sv
// rtl/pad_in_filter.sv - pad input synchronizer plus glitch filter
// chg_o flags that in_data_o toggles on the coming edge.
module pad_in_filter
  import pad_io_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              pad_o_i,
  output logic              in_data_o,
  output logic              chg_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   in_data_q, in_data_d;
  logic                   synced;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign in_data_o = in_data_q;

  // Counter only advances while the synced value disagrees with the output.
  always_comb begin
    cnt_d     = '0;
    in_data_d = in_data_q;
    chg_o     = 1'b0;
    if (en_i && (synced != in_data_q)) begin
      if (cnt_q == filt_len_i) begin
        in_data_d = ~in_data_q;
        chg_o     = 1'b1;
      end else begin
        cnt_d = cnt_q + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      in_data_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_o_i};
      cnt_q     <= cnt_d;
      in_data_q <= in_data_d;
    end
  end

endmodule

// File: rtl/pad_io_ctrl.sv
// rtl/pad_io_ctrl.sv - bidirectional pad controller with turnaround FSM and filtered input
// Define PAD_IO_CTRL_EDGE_EN to generate rise_o/fall_o; otherwise both are tied to 0.
module pad_io_ctrl
  import pad_io_ctrl_pkg::*;
#(
  parameter int TURN_CYC    = TURN_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dir_req_i,
  input  logic              out_data_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              pad_oen_o,
  output logic              pad_i_o,
  input  logic              pad_o_i,
  output logic              dir_o,
  output logic              busy_o,
  output logic              in_data_o,
  output logic              rise_o,
  output logic              fall_o
);

  localparam int              TC_W    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  pad_state_e      state_q, state_d;
  logic [TC_W-1:0] tc_q, tc_d;
  logic            oen_q, dir_q, busy_q, pad_i_q;
  logic            flt_data, flt_chg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IN;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  // Requests are only looked at in IN/OUT, so turnarounds always run to completion.
  always_comb begin
    state_d = state_q;
    tc_d    = '0;
    case (state_q)
      ST_IN:     if (dir_req_i) state_d = (TURN_CYC == 0) ? ST_OUT : ST_TO_OUT;
      ST_TO_OUT: begin
        if (tc_q == TC_LAST) state_d = ST_OUT;
        else                 tc_d    = tc_q + TC_W'(1);
      end
      ST_OUT:    if (!dir_req_i) state_d = (TURN_CYC == 0) ? ST_IN : ST_TO_IN;
      ST_TO_IN: begin
        if (tc_q == TC_LAST) state_d = ST_IN;
        else                 tc_d    = tc_q + TC_W'(1);
      end
      default:   state_d = ST_IN;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oen_q   <= 1'b1;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      pad_i_q <= 1'b0;
    end else begin
      oen_q  <= (state_d != ST_OUT);
      dir_q  <= (state_d == ST_OUT);
      busy_q <= (state_d == ST_TO_OUT) || (state_d == ST_TO_IN);
      if ((state_q == ST_TO_OUT) || (state_q == ST_OUT)) pad_i_q <= out_data_i;
    end
  end

  assign pad_oen_o = oen_q;
  assign dir_o     = dir_q;
  assign busy_o    = busy_q;
  assign pad_i_o   = pad_i_q;
  assign in_data_o = flt_data;

  pad_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_pad_in_filter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (state_q == ST_IN),
    .filt_len_i (filt_len_i),
    .pad_o_i    (pad_o_i),
    .in_data_o  (flt_data),
    .chg_o      (flt_chg)
  );

`ifdef PAD_IO_CTRL_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= flt_chg & ~flt_data;
      fall_q <= flt_chg & flt_data;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  logic edge_unused;
  assign edge_unused = flt_chg;
  assign rise_o      = 1'b0;
  assign fall_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pad_io_ctrl.sv
// tb/tb_pad_io_ctrl.sv - self-checking bench for pad_io_ctrl with a behavioural reference model
module tb_pad_io_ctrl;

  localparam int TC = 2;
  localparam int SS = 2;
  localparam int FW = 4;
`ifdef PAD_IO_CTRL_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, dir_req, out_data, pad_o;
  logic [FW-1:0] filt_len;
  logic          pad_oen, pad_i, dir, busy, in_data, rise, fall;

  always #5 clk = ~clk;

  pad_io_ctrl #(.TURN_CYC(TC), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .dir_req_i  (dir_req),
    .out_data_i (out_data),
    .filt_len_i (filt_len),
    .pad_oen_o  (pad_oen),
    .pad_i_o    (pad_i),
    .pad_o_i    (pad_o),
    .dir_o      (dir),
    .busy_o     (busy),
    .in_data_o  (in_data),
    .rise_o     (rise),
    .fall_o     (fall)
  );

  int n_checks = 0;
  int n_err    = 0;

  wire [6:0] dut_vec = {pad_oen, pad_i, dir, busy, in_data, rise, fall};

  // Reference model: mode 0=receive, 1=going out, 2=driving, 3=going in.
  int        m_mode, m_left;
  bit        m_pad_i, m_in, m_rise, m_fall;
  bit [FW-1:0] m_run;
  bit        m_hist[$];

  always @(posedge clk) begin : model
    bit synced;
    int old;
    if (rst) begin
      m_mode = 0; m_left = 0; m_pad_i = 0; m_in = 0; m_run = '0;
      m_rise = 0; m_fall = 0;
      m_hist = {};
      repeat (SS) m_hist.push_back(1'b0);
    end else begin
      old    = m_mode;
      synced = m_hist[SS-1];
      if (old == 1 || old == 2) m_pad_i = out_data;
      m_rise = 0;
      m_fall = 0;
      if (old != 0 || synced == m_in) m_run = '0;
      else if (m_run == filt_len) begin
        m_in   = !m_in;
        m_rise = EDGE_EN && m_in;
        m_fall = EDGE_EN && !m_in;
        m_run  = '0;
      end else m_run++;
      m_hist.push_front(pad_o);
      void'(m_hist.pop_back());
      case (old)
        0: if (dir_req) begin m_mode = (TC == 0) ? 2 : 1; m_left = TC; end
        1: begin m_left--; if (m_left == 0) m_mode = 2; end
        2: if (!dir_req) begin m_mode = (TC == 0) ? 0 : 3; m_left = TC; end
        default: begin m_left--; if (m_left == 0) m_mode = 0; end
      endcase
    end
  end

  function automatic logic [6:0] exp_vec();
    return {m_mode != 2, m_pad_i, m_mode == 2, (m_mode == 1 || m_mode == 3), m_in, m_rise, m_fall};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; dir_req = 0; out_data = 0; pad_o = 0; filt_len = 4'd3;
    step(); step();
    n_checks++;
    if (dut_vec !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", dut_vec, 7'b1000000);
    end
    rst = 0;
  endtask

  task automatic test_to_out();
    logic [2:0] want [4];
    want = '{3'b110, 3'b110, 3'b001, 3'b001};
    dir_req = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if ({pad_oen, busy, dir} !== want[c]) begin
        n_err++;
        $display("FAIL to_out cyc%0d {oen,busy,dir}: got %b want %b", c, {pad_oen, busy, dir}, want[c]);
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL to_out_model cyc%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      out_data = 1'($urandom);
    end
  endtask

  task automatic test_to_in();
    logic [2:0] want [4];
    want = '{3'b110, 3'b110, 3'b100, 3'b100};
    dir_req = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if ({pad_oen, busy, dir} !== want[c]) begin
        n_err++;
        $display("FAIL to_in cyc%0d {oen,busy,dir}: got %b want %b", c, {pad_oen, busy, dir}, want[c]);
      end
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL to_in_model cyc%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      out_data = 1'($urandom);
    end
  endtask

  task automatic test_filter_latency();
    int lat;
    logic edge_seen;
    filt_len = 4'd3;
    for (int dirn = 1; dirn >= 0; dirn--) begin
      pad_o = 1'(dirn);
      lat = -1;
      edge_seen = 1'b0;
      for (int k = 1; k <= 12; k++) begin
        step();
        if (lat < 0 && in_data === 1'(dirn)) begin
          lat = k;
          edge_seen = dirn ? rise : fall;
        end
      end
      n_checks++;
      if (lat != SS + 3 + 1) begin
        n_err++;
        $display("FAIL filter_latency to %0d: got %0d want %0d", dirn, lat, SS + 4);
      end
      n_checks++;
      if (edge_seen !== EDGE_EN) begin
        n_err++;
        $display("FAIL edge_pulse to %0d: got %b want %b", dirn, edge_seen, EDGE_EN);
      end
    end
  endtask

  task automatic test_glitch();
    logic seen;
    for (int len = 3; len <= 4; len++) begin
      seen = 1'b0;
      pad_o = 1;
      for (int k = 0; k < 14; k++) begin
        if (k == len) pad_o = 0;
        step();
        seen |= in_data | rise;
      end
      n_checks++;
      if (seen !== (len == 4)) begin
        n_err++;
        $display("FAIL glitch_len%0d: got seen=%b want %b", len, seen, len == 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    dir_req = 1; step();
    dir_req = 0; step();
    n_checks++;
    if ({pad_oen, busy, dir} !== 3'b110) begin
      n_err++;
      $display("FAIL toggle_mid_turn: got %b want %b", {pad_oen, busy, dir}, 3'b110);
    end
    step();
    n_checks++;
    if ({pad_oen, busy, dir} !== 3'b001) begin
      n_err++;
      $display("FAIL toggle_reach_out: got %b want %b", {pad_oen, busy, dir}, 3'b001);
    end
    step();
    n_checks++;
    if ({pad_oen, busy, dir} !== 3'b110) begin
      n_err++;
      $display("FAIL toggle_then_to_in: got %b want %b", {pad_oen, busy, dir}, 3'b110);
    end
    step(); step(); step();
  endtask

  task automatic test_reset_in_out();
    pad_o = 1;
    repeat (8) step();
    dir_req = 1; out_data = 1;
    repeat (4) step();
    n_checks++;
    if ({pad_oen, pad_i, dir, in_data} !== 4'b0111) begin
      n_err++;
      $display("FAIL pre_reset_drive: got %b want %b", {pad_oen, pad_i, dir, in_data}, 4'b0111);
    end
    rst = 1; pad_o = 0;
    step();
    n_checks++;
    if (dut_vec !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_in_out: got %b want %b", dut_vec, 7'b1000000);
    end
    rst = 0; dir_req = 0; out_data = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      step();
      n_checks++;
      if (dut_vec !== exp_vec() || (rise && fall)) begin
        n_err++;
        $display("FAIL random cyc%0d: got %b want %b", c, dut_vec, exp_vec());
      end
      rst = ($urandom_range(0, 499) == 0);
      if (rst) filt_len = FW'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) dir_req = ~dir_req;
      out_data = 1'($urandom);
      if ($urandom_range(0, 3) == 0) pad_o = ~pad_o;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_to_out();
    test_to_in();
    test_filter_latency();
    test_glitch();
    test_back_to_back();
    test_reset_in_out();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
